// File: rtl/switch_router_pkg.sv
// Shared helpers for switch_router: port decode and width calculations.
package switch_router_pkg;

  function automatic int unsigned port_w_f(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Address ranges above the last port all land on the last port.
  function automatic int unsigned port_idx_f(input logic [31:0] addr,
                                             input int unsigned shift,
                                             input int unsigned num_ports);
    logic [31:0] idx;
    idx = addr >> shift;
    if (idx > 32'(num_ports - 1)) return num_ports - 1;
    return idx;
  endfunction

endpackage

// File: rtl/switch_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on dout whenever not empty.
module switch_fifo
  import switch_router_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; count gates visibility, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/switch_router.sv
// Address-routed switch: one input stream steered into per-port show-ahead FIFOs.
module switch_router
  import switch_router_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_SHIFT = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         in_vld,
  output logic                                         in_rdy,
  input  logic [ADDR_WIDTH-1:0]                        in_addr,
  input  logic [DATA_WIDTH-1:0]                        in_data,
  output logic [NUM_PORTS-1:0]                         out_vld,
  input  logic [NUM_PORTS-1:0]                         out_rdy,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]              out_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]              out_data,
  output logic [NUM_PORTS*$clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt
);

  localparam int PORT_W = port_w_f(NUM_PORTS);
  localparam int CNT_W  = cnt_w_f(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t                 in_beat;
  logic [PORT_W-1:0]     tgt;
  logic [NUM_PORTS-1:0]  full_vec;

  assign in_beat = '{addr: in_addr, data: in_data};
  assign tgt     = PORT_W'(port_idx_f(32'(in_addr), ADDR_SHIFT, NUM_PORTS));

  // Depends only on the address and registered counts, never on out_rdy.
  assign in_rdy  = ~full_vec[tgt];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    beat_t             head;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;

    assign push = in_vld & in_rdy & (tgt == PORT_W'(p));
    assign pop  = out_rdy[p] & ~empty;

    switch_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .din   (in_beat),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (cnt)
    );

    assign full_vec[p]                             = full;
    assign out_vld[p]                              = ~empty;
    assign out_addr[p*ADDR_WIDTH +: ADDR_WIDTH]    = empty ? '0 : head.addr;
    assign out_data[p*DATA_WIDTH +: DATA_WIDTH]    = empty ? '0 : head.data;
    assign fifo_cnt[p*CNT_W +: CNT_W]              = cnt;
  end

endmodule

// File: tb/tb_switch_router.sv
// Directed bench for switch_router: routing, back-pressure, streaming, clamp and reset.
module tb_switch_router;

  logic        clk;
  logic        rstn;

  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  in_addr;
  logic [15:0] in_data;
  logic [3:0]  out_vld;
  logic [3:0]  out_rdy;
  logic [31:0] out_addr;
  logic [63:0] out_data;
  logic [11:0] fifo_cnt;

  logic        in_vld2;
  logic        in_rdy2;
  logic [7:0]  in_addr2;
  logic [15:0] in_data2;
  logic [1:0]  out_vld2;
  logic [1:0]  out_rdy2;
  logic [15:0] out_addr2;
  logic [31:0] out_data2;
  logic [5:0]  fifo_cnt2;

  int tests_run;
  int tests_failed;

  switch_router #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_PORTS(4), .ADDR_SHIFT(6), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr),
    .in_data(in_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr),
    .out_data(out_data), .fifo_cnt(fifo_cnt)
  );

  switch_router #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_PORTS(2), .ADDR_SHIFT(6), .FIFO_DEPTH(4)
  ) u_dut2 (
    .clk(clk), .rstn(rstn), .in_vld(in_vld2), .in_rdy(in_rdy2), .in_addr(in_addr2),
    .in_data(in_data2), .out_vld(out_vld2), .out_rdy(out_rdy2), .out_addr(out_addr2),
    .out_data(out_data2), .fifo_cnt(fifo_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn    = 1'b0;
    in_vld  = 1'b0;
    out_rdy = '0;
    in_vld2 = 1'b0;
    out_rdy2 = '0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_vld = 1'b0; in_addr = '0; in_data = '0; out_rdy = '0;
    in_vld2 = 1'b0; in_addr2 = '0; in_data2 = '0; out_rdy2 = '0;
    #2;
    tests_run++;
    if (out_vld !== 4'h0) begin tests_failed++; $display("FAIL reset_out_vld: got %h expected 0", out_vld); end
    tests_run++;
    if (fifo_cnt !== 12'h0) begin tests_failed++; $display("FAIL reset_fifo_cnt: got %h expected 0", fifo_cnt); end
    tests_run++;
    if (out_data !== 64'h0 || out_addr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_out_bus: got addr %h data %h expected 0", out_addr, out_data);
    end
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_in_rdy: got %b expected 1", in_rdy); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_route();
    logic [7:0] addrs [4];
    addrs = '{8'h10, 8'h50, 8'h90, 8'hD0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_addr = addrs[i]; in_data = 16'hA001 + 16'(i);
      #1;
      tests_run++;
      if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL route_in_rdy[%0d]: got %b expected 1", i, in_rdy); end
      tick();
      tests_run++;
      if (out_vld[i] !== 1'b1) begin tests_failed++; $display("FAIL route_latency[%0d]: got %b expected 1", i, out_vld[i]); end
    end
    in_vld = 1'b0;
    tick();
    tests_run++;
    if (fifo_cnt !== 12'h249) begin tests_failed++; $display("FAIL route_fifo_cnt: got %h expected 249", fifo_cnt); end
    tests_run++;
    if (out_vld !== 4'hF) begin tests_failed++; $display("FAIL route_out_vld: got %h expected f", out_vld); end
    tests_run++;
    if (out_addr !== 32'hD090_5010) begin tests_failed++; $display("FAIL route_out_addr: got %h expected d0905010", out_addr); end
    tests_run++;
    if (out_data !== 64'hA004_A003_A002_A001) begin
      tests_failed++; $display("FAIL route_out_data: got %h expected a004a003a002a001", out_data);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_rdy = 4'h0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_addr = 8'h80; in_data = 16'hB000 + 16'(i);
      #1;
      tests_run++;
      if (in_rdy !== (i < 4)) begin tests_failed++; $display("FAIL bp_in_rdy[%0d]: got %b expected %b", i, in_rdy, (i < 4)); end
      tick();
    end
    tests_run++;
    if (fifo_cnt[6 +: 3] !== 3'd4) begin tests_failed++; $display("FAIL bp_cnt_full: got %0d expected 4", fifo_cnt[6 +: 3]); end
    in_vld = 1'b0; in_addr = 8'h00;
    #1;
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL bp_other_port_rdy: got %b expected 1", in_rdy); end
    in_addr = 8'h80;
    out_rdy = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (out_vld[2] !== 1'b1 || out_data[32 +: 16] !== 16'hB000 + 16'(i)) begin
        tests_failed++;
        $display("FAIL bp_drain[%0d]: got vld %b data %h expected vld 1 data %h", i, out_vld[2], out_data[32 +: 16], 16'hB000 + 16'(i));
      end
      tick();
    end
    tests_run++;
    if (out_vld[2] !== 1'b0 || fifo_cnt[6 +: 3] !== 3'd0) begin
      tests_failed++; $display("FAIL bp_empty: got vld %b cnt %0d expected 0 0", out_vld[2], fifo_cnt[6 +: 3]);
    end
    out_rdy = 4'h0;
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_addr = 8'h40; in_data = 16'hC000 + 16'(i);
      tick();
    end
    tests_run++;
    if (fifo_cnt[3 +: 3] !== 3'd4) begin tests_failed++; $display("FAIL fp_cnt_before: got %0d expected 4", fifo_cnt[3 +: 3]); end
    in_data = 16'hC004; out_rdy = 4'b0010;
    #1;
    tests_run++;
    if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL fp_refused: got in_rdy %b expected 0", in_rdy); end
    tick();
    tests_run++;
    if (fifo_cnt[3 +: 3] !== 3'd3) begin tests_failed++; $display("FAIL fp_cnt_after_pop: got %0d expected 3", fifo_cnt[3 +: 3]); end
    out_rdy = 4'h0;
    #1;
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL fp_accept_next: got in_rdy %b expected 1", in_rdy); end
    tick();
    in_vld = 1'b0;
    tests_run++;
    if (fifo_cnt[3 +: 3] !== 3'd4) begin tests_failed++; $display("FAIL fp_cnt_refill: got %0d expected 4", fifo_cnt[3 +: 3]); end
    out_rdy = 4'b0010;
    for (int i = 1; i < 5; i++) begin
      #1;
      tests_run++;
      if (out_data[16 +: 16] !== 16'hC000 + 16'(i)) begin
        tests_failed++; $display("FAIL fp_order[%0d]: got %h expected %h", i, out_data[16 +: 16], 16'hC000 + 16'(i));
      end
      tick();
    end
    out_rdy = 4'h0;
  endtask

  task automatic test_stream();
    logic [7:0]  a;
    int          p;
    logic [15:0] d;
    apply_reset();
    out_rdy = 4'hF;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i * 37 + 5);
      p = int'(a >> 6);
      d = 16'hD000 + 16'(i);
      in_vld = 1'b1; in_addr = a; in_data = d;
      #1;
      tests_run++;
      if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL stream_in_rdy[%0d]: got %b expected 1", i, in_rdy); end
      tick();
      tests_run++;
      if (out_vld !== 4'(1 << p) || out_addr[p*8 +: 8] !== a || out_data[p*16 +: 16] !== d) begin
        tests_failed++;
        $display("FAIL stream_beat[%0d]: got vld %h addr %h data %h expected vld %h addr %h data %h",
                 i, out_vld, out_addr[p*8 +: 8], out_data[p*16 +: 16], 4'(1 << p), a, d);
      end
    end
    in_vld = 1'b0;
    tick();
    tests_run++;
    if (out_vld !== 4'h0) begin tests_failed++; $display("FAIL stream_drained: got %h expected 0", out_vld); end
    out_rdy = 4'h0;
  endtask

  task automatic test_clamp();
    logic [7:0] addrs [3];
    addrs = '{8'h3F, 8'h40, 8'hFF};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      in_vld2 = 1'b1; in_addr2 = addrs[i]; in_data2 = 16'hE001 + 16'(i);
      tick();
    end
    in_vld2 = 1'b0;
    tests_run++;
    if (fifo_cnt2 !== 6'h11) begin tests_failed++; $display("FAIL clamp_cnt: got %h expected 11", fifo_cnt2); end
    tests_run++;
    if (out_addr2 !== 16'h403F) begin tests_failed++; $display("FAIL clamp_addr: got %h expected 403f", out_addr2); end
    tests_run++;
    if (out_data2 !== 32'hE002_E001) begin tests_failed++; $display("FAIL clamp_data: got %h expected e002e001", out_data2); end
    out_rdy2 = 2'b10;
    tick();
    out_rdy2 = 2'b00;
    tests_run++;
    if (out_addr2[15:8] !== 8'hFF || out_data2[31:16] !== 16'hE003) begin
      tests_failed++; $display("FAIL clamp_ff: got addr %h data %h expected ff e003", out_addr2[15:8], out_data2[31:16]);
    end
  endtask

  task automatic test_midreset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_addr = 8'h00; in_data = 16'hF001 + 16'(i);
      tick();
    end
    tests_run++;
    if (fifo_cnt[0 +: 3] !== 3'd3) begin tests_failed++; $display("FAIL mr_cnt_before: got %0d expected 3", fifo_cnt[0 +: 3]); end
    #2;
    rstn = 1'b0;
    #1;
    tests_run++;
    if (out_vld !== 4'h0 || fifo_cnt !== 12'h0 || out_data !== 64'h0) begin
      tests_failed++; $display("FAIL mr_async: got vld %h cnt %h data %h expected 0 0 0", out_vld, fifo_cnt, out_data);
    end
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL mr_in_rdy: got %b expected 1", in_rdy); end
    tick();
    in_vld = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tests_run++;
    if (out_vld !== 4'h0 || fifo_cnt !== 12'h0) begin
      tests_failed++; $display("FAIL mr_no_replay: got vld %h cnt %h expected 0 0", out_vld, fifo_cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_route();
    test_backpressure();
    test_full_pop();
    test_stream();
    test_clamp();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/switch_router.md
# switch_router

Parametrised address-routed switch. Steers each accepted input beat (addr, data) to one of NUM_PORTS output ports by address range, and buffers it in a per-port show-ahead FIFO. Uses valid/ready flow control on both sides, so output back-pressure no longer loses data. Sits between a single request source and NUM_PORTS downstream consumers; with NUM_PORTS=2 and ADDR_SHIFT=6, routing is 0x00–0x3F to port 0 and everything else to port 1.

## Interface
- ADDR_WIDTH, 8: address width.
- DATA_WIDTH, 16: data width.
- NUM_PORTS, 4: output port count, 2..16.
- ADDR_SHIFT, 6: address bits per port range; port = min(addr >> ADDR_SHIFT, NUM_PORTS-1).
- FIFO_DEPTH, 4: entries per port FIFO, power of two, ≥2.
- Clocking/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  input beat accepted this cycle when in_vld & in_rdy.
- in_addr  in  ADDR_WIDTH  beat address, also the routing key.
- in_data  in  DATA_WIDTH  beat payload.
- out_vld  out  NUM_PORTS  per-port head entry valid.
- out_rdy  in  NUM_PORTS  per-port consumer ready.
- out_addr  out  NUM_PORTS*ADDR_WIDTH  per-port head address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- out_data  out  NUM_PORTS*DATA_WIDTH  per-port head data, same packing.
- fifo_cnt  out  NUM_PORTS*$clog2(FIFO_DEPTH+1)  per-port occupancy.

## Operation
- Target port is computed combinationally from in_addr. Addresses above the last range clamp to port NUM_PORTS-1. No beat is ever dropped.
- in_rdy = !full[target]. It is independent of out_rdy, so there is no combinational in→out ready path. in_rdy is meaningful even when in_vld=0.
- Push: when in_vld & in_rdy, {in_addr, in_data} is written to the target FIFO. Only one FIFO is written per cycle.
- Pop: port p pops when out_vld[p] & out_rdy[p]. Ports pop independently and concurrently.
- Per port: out_vld[p] = (count>0). out_addr/out_data present the head entry and are forced to 0 when out_vld[p]=0.
- Simultaneous push and pop on the same port: count is unchanged and both take effect.
  - Full FIFO with pop: in_rdy stays 0 that cycle; the push is refused.
  - Empty FIFO with push: that entry is not visible until the next cycle; no bypass.
- Pointers wrap modulo FIFO_DEPTH. Count saturates by construction, never exceeding FIFO_DEPTH or dropping below 0.
- Reset (asynchronous assert, any time): all FIFOs empty, pointers and counts 0, out_vld=0, out_addr=0, out_data=0, fifo_cnt=0. Buffered beats are discarded. in_rdy=1 while and after reset, since all FIFOs are empty; beats presented while rstn=0 are not stored.

## Timing
- Latency: a beat accepted at rising edge t gives out_vld[p]=1 with that beat from just after edge t; it is poppable at edge t+1.
- Throughput: 1 beat/cycle in, and up to 1 beat/cycle per port out.
- fifo_cnt, out_vld, out_addr and out_data are registered state or a mux of registered state; no input-to-output combinational path.
- in_rdy is combinational from in_addr and registered counts only.

## Structure
- Package switch_router_pkg:
  - port_idx_f(addr) function implementing the shift and clamp.
  - PORT_W = $clog2(NUM_PORTS) and CNT_W = $clog2(FIFO_DEPTH+1) helpers.
  - Packed beat typedef {addr, data}.
- Sub-module switch_fifo: synchronous show-ahead FIFO with push/pop/full/empty/count and asynchronous active-low reset, instantiated NUM_PORTS times in a generate loop.
- Top level: port decode, in_rdy mux, output gating.

## Test plan
- Reset then route: push addr 0x10/0x50/0x90/0xD0, data 0xA001–0xA004, out_rdy=0 → each port holds one beat, fifo_cnt=1 each, out_addr[p] matches, in_rdy=1 throughout.
- Back-pressure: with out_rdy[2]=0, push 5 beats to addr 0x80 → 4 accepted; in_rdy=0 on the 5th while addr stays 0x80. Change addr to 0x00 → in_rdy=1 immediately. Raise out_rdy[2] → port 2 pops in order, one per cycle.
- Full with simultaneous pop: port 1 full, out_rdy[1]=1, push to 0x40 → refused that cycle; accepted next cycle; count goes 4→3→4.
- Streaming: out_rdy all 1, 20 back-to-back beats with random addr → every beat appears on its port exactly once, in order, 1 cycle after acceptance.
- Clamp with NUM_PORTS=2, ADDR_SHIFT=6: addr 0x3F → port 0; addr 0x40 and 0xFF → port 1.
- Mid-operation reset: 3 beats buffered on port 0, drop rstn asynchronously between edges → out_vld=0, fifo_cnt=0, out_data=0 immediately; nothing from before reset is replayed after release.
